// File: rtl/multicyc_ctrl_unit.sv
// multicyc_ctrl_unit
// Control sequencer for the multi-cycle MIPS core. The instruction and data
// memories share one port, and the PC and branch adders are folded into the
// main ALU. Each instruction steps through FETCH, DECODE, EXEC-type, memory
// and writeback states. Memory states stall on iMemReady.
//
// Optional build macro: MULTICYC_JR_EN
//   defined   : R-type funct 0x08 (JR) goes to state JR (12) and loads PC from rs
//   undefined : R-type funct 0x08 is treated as an illegal instruction
//
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   iOpCode, iFunct     opcode / funct from the instruction register
//   iAluZero            ALU zero flag (consumed by the datapath PC-write gate)
//   iMemReady           memory completed the current access this cycle
//   oPCWrite ..         datapath mux selects, write enables and ALUOp
//   oRetire             pulse on the last cycle of each completed instruction
//   oIllegal            pulse when an unsupported opcode/funct is decoded
//   oState              current state, for debug
module multicyc_ctrl_unit #(
  parameter int STATE_W = 4
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [5:0]         iOpCode,
  input  logic [5:0]         iFunct,
  input  logic               iAluZero,
  input  logic               iMemReady,
  output logic               oPCWrite,
  output logic               oPCWriteCond,
  output logic               oBranchEq,
  output logic [1:0]         oPCSource,
  output logic               oIorD,
  output logic               oMemRead,
  output logic               oMemWrite,
  output logic               oIRWrite,
  output logic               oALUSrcA,
  output logic [1:0]         oALUSrcB,
  output logic [1:0]         oALUOp,
  output logic               oRegWrite,
  output logic               oRegDst,
  output logic               oMemtoReg,
  output logic               oRetire,
  output logic               oIllegal,
  output logic [STATE_W-1:0] oState
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADDR  = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXEC     = STATE_W'(6),
    S_RWB      = STATE_W'(7),
    S_BRANCH   = STATE_W'(8),
    S_JUMP     = STATE_W'(9),
    S_IEXEC    = STATE_W'(10),
    S_IWB      = STATE_W'(11),
    S_JR       = STATE_W'(12)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t state_q, state_d;

  // The zero flag is combined with oPCWriteCond/oBranchEq in the datapath.
  logic unused_alu_zero;
  assign unused_alu_zero = iAluZero;

  always_ff @(posedge iClk) begin
    if (iRst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  assign oState = state_q;

  always_comb begin
    state_d      = S_FETCH;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oBranchEq    = 1'b0;
    oPCSource    = 2'b00;
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oIRWrite     = 1'b0;
    oALUSrcA     = 1'b0;
    oALUSrcB     = 2'b00;
    oALUOp       = 2'b00;
    oRegWrite    = 1'b0;
    oRegDst      = 1'b0;
    oMemtoReg    = 1'b0;
    oRetire      = 1'b0;
    oIllegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        oMemRead = 1'b1;
        oALUSrcB = 2'b01;
        if (iMemReady) begin
          oIRWrite = 1'b1;
          oPCWrite = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALU precomputes PC + (imm << 2) for a possible branch.
        oALUSrcB = 2'b11;
        case (iOpCode)
          OP_LW, OP_SW:   state_d = S_MEMADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI:
                          state_d = S_IEXEC;
          OP_RTYPE: begin
`ifdef MULTICYC_JR_EN
            if (iFunct == FN_JR) state_d = S_JR;
            else                 state_d = S_EXEC;
`else
            if (iFunct == FN_JR) begin
              state_d  = S_FETCH;
              oIllegal = 1'b1;
            end else begin
              state_d  = S_EXEC;
            end
`endif
          end
          default: begin
            state_d  = S_FETCH;
            oIllegal = 1'b1;
          end
        endcase
      end
      S_MEMADDR: begin
        oALUSrcA = 1'b1;
        oALUSrcB = 2'b10;
        state_d  = (iOpCode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        oMemRead = 1'b1;
        oIorD    = 1'b1;
        state_d  = iMemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        oRegWrite = 1'b1;
        oMemtoReg = 1'b1;
        oRetire   = 1'b1;
      end
      S_MEMWRITE: begin
        oMemWrite = 1'b1;
        oIorD     = 1'b1;
        oRetire   = iMemReady;
        state_d   = iMemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXEC: begin
        oALUSrcA = 1'b1;
        oALUOp   = 2'b10;
        state_d  = S_RWB;
      end
      S_RWB: begin
        oRegWrite = 1'b1;
        oRegDst   = 1'b1;
        oRetire   = 1'b1;
      end
      S_BRANCH: begin
        oALUSrcA     = 1'b1;
        oALUOp       = 2'b01;
        oPCWriteCond = 1'b1;
        oBranchEq    = (iOpCode == OP_BEQ);
        oPCSource    = 2'b01;
        oRetire      = 1'b1;
      end
      S_JUMP: begin
        oPCWrite  = 1'b1;
        oPCSource = 2'b10;
        oRetire   = 1'b1;
      end
      S_IEXEC: begin
        oALUSrcA = 1'b1;
        oALUSrcB = 2'b10;
        oALUOp   = 2'b11;
        state_d  = S_IWB;
      end
      S_IWB: begin
        oRegWrite = 1'b1;
        oRetire   = 1'b1;
      end
`ifdef MULTICYC_JR_EN
      S_JR: begin
        oPCWrite  = 1'b1;
        oPCSource = 2'b11;
        oRetire   = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Reset abandons the instruction: no enable may fire in the reset cycle.
    if (iRst) begin
      oPCWrite     = 1'b0;
      oPCWriteCond = 1'b0;
      oMemRead     = 1'b0;
      oMemWrite    = 1'b0;
      oIRWrite     = 1'b0;
      oRegWrite    = 1'b0;
      oRetire      = 1'b0;
      oIllegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicyc_ctrl_unit.sv
module tb_multicyc_ctrl_unit;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, beq;
    logic [1:0] pcsrc;
    logic       iord, mrd, mwr, irw, asa;
    logic [1:0] asb, aop;
    logic       rw, rdst, m2r, ret, ill;
  } outs_t;

  typedef struct packed {
    logic  rst;
    int    idx;
    outs_t o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] fn = '0;
  logic       zero = 1'b0;
  logic       rdy = 1'b0;

  logic       pcw, pcwc, beq, iord, mrd, mwr, irw, asa, rw, rdst, m2r, ret, ill;
  logic [1:0] pcsrc, asb, aop;
  logic [3:0] st;

  int checks = 0;
  int failures = 0;
  int row = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  multicyc_ctrl_unit #(.STATE_W(4)) dut (
    .iClk(clk), .iRst(rst), .iOpCode(op), .iFunct(fn), .iAluZero(zero),
    .iMemReady(rdy), .oPCWrite(pcw), .oPCWriteCond(pcwc), .oBranchEq(beq),
    .oPCSource(pcsrc), .oIorD(iord), .oMemRead(mrd), .oMemWrite(mwr),
    .oIRWrite(irw), .oALUSrcA(asa), .oALUSrcB(asb), .oALUOp(aop),
    .oRegWrite(rw), .oRegDst(rdst), .oMemtoReg(m2r), .oRetire(ret),
    .oIllegal(ill), .oState(st)
  );

  // Hand-written per-state output table.
  function automatic outs_t expect_outs(input logic [3:0] s, input logic r,
                                        input logic [5:0] o, input logic il);
    outs_t e = '0;
    e.st = s;
    case (s)
      4'd0:  begin e.mrd = 1; e.asb = 2'b01; e.irw = r; e.pcw = r; end
      4'd1:  begin e.asb = 2'b11; e.ill = il; end
      4'd2:  begin e.asa = 1; e.asb = 2'b10; end
      4'd3:  begin e.mrd = 1; e.iord = 1; end
      4'd4:  begin e.rw = 1; e.m2r = 1; e.ret = 1; end
      4'd5:  begin e.mwr = 1; e.iord = 1; e.ret = r; end
      4'd6:  begin e.asa = 1; e.aop = 2'b10; end
      4'd7:  begin e.rw = 1; e.rdst = 1; e.ret = 1; end
      4'd8:  begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.beq = (o == 6'h04);
                   e.pcsrc = 2'b01; e.ret = 1; end
      4'd9:  begin e.pcw = 1; e.pcsrc = 2'b10; e.ret = 1; end
      4'd10: begin e.asa = 1; e.asb = 2'b10; e.aop = 2'b11; end
      4'd11: begin e.rw = 1; e.ret = 1; end
      4'd12: begin e.pcw = 1; e.pcsrc = 2'b11; e.ret = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [11:0] enables(input outs_t v);
    return {v.st, v.pcw, v.pcwc, v.mrd, v.mwr, v.irw, v.rw, v.ret, v.ill};
  endfunction

  // One cycle of stimulus with its expected state and illegal flag.
  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic rd, input logic z, input logic [3:0] s,
                     input logic il);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; op = o; fn = f; rdy = rd; zero = z;
    e.rst = r;
    e.idx = row;
    e.o = expect_outs(s, rd, o, il);
    if (r) e.o = '{st: s, default: '0};
    q.push_back(e);
    row++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      outs_t a;
      e = q.pop_front();
      a = '{st: st, pcw: pcw, pcwc: pcwc, beq: beq, pcsrc: pcsrc, iord: iord,
            mrd: mrd, mwr: mwr, irw: irw, asa: asa, asb: asb, aop: aop,
            rw: rw, rdst: rdst, m2r: m2r, ret: ret, ill: ill};
      checks++;
      if (e.rst) begin
        if (enables(a) !== enables(e.o)) begin
          failures++;
          $display("FAIL row%0d reset_enables got=%h exp=%h", e.idx, enables(a), enables(e.o));
        end
      end else if (a !== e.o) begin
        failures++;
        $display("FAIL row%0d outputs got=%h exp=%h", e.idx, a, e.o);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    cyc(1, 6'h00, 6'h00, 0, 0, 4'd0, 0);
    // LW with 2 wait cycles in FETCH and MEMREAD
    cyc(0, 6'h23, 6'h00, 0, 0, 4'd0, 0);
    cyc(0, 6'h23, 6'h00, 0, 0, 4'd0, 0);
    cyc(0, 6'h23, 6'h00, 1, 0, 4'd0, 0);
    cyc(0, 6'h23, 6'h00, 0, 0, 4'd1, 0);
    cyc(0, 6'h23, 6'h00, 0, 0, 4'd2, 0);
    cyc(0, 6'h23, 6'h00, 0, 0, 4'd3, 0);
    cyc(0, 6'h23, 6'h00, 0, 0, 4'd3, 0);
    cyc(0, 6'h23, 6'h00, 1, 0, 4'd3, 0);
    cyc(0, 6'h23, 6'h00, 0, 0, 4'd4, 0);
    // BEQ then BNE, zero flag high
    cyc(0, 6'h04, 6'h00, 1, 1, 4'd0, 0);
    cyc(0, 6'h04, 6'h00, 1, 1, 4'd1, 0);
    cyc(0, 6'h04, 6'h00, 1, 1, 4'd8, 0);
    cyc(0, 6'h05, 6'h00, 1, 1, 4'd0, 0);
    cyc(0, 6'h05, 6'h00, 1, 1, 4'd1, 0);
    cyc(0, 6'h05, 6'h00, 1, 1, 4'd8, 0);
    // ADD then ADDI
    cyc(0, 6'h00, 6'h20, 1, 0, 4'd0, 0);
    cyc(0, 6'h00, 6'h20, 1, 0, 4'd1, 0);
    cyc(0, 6'h00, 6'h20, 1, 0, 4'd6, 0);
    cyc(0, 6'h00, 6'h20, 1, 0, 4'd7, 0);
    cyc(0, 6'h08, 6'h00, 1, 0, 4'd0, 0);
    cyc(0, 6'h08, 6'h00, 1, 0, 4'd1, 0);
    cyc(0, 6'h08, 6'h00, 1, 0, 4'd10, 0);
    cyc(0, 6'h08, 6'h00, 1, 0, 4'd11, 0);
    // J
    cyc(0, 6'h02, 6'h00, 1, 0, 4'd0, 0);
    cyc(0, 6'h02, 6'h00, 1, 0, 4'd1, 0);
    cyc(0, 6'h02, 6'h00, 1, 0, 4'd9, 0);
    // LW without waits
    cyc(0, 6'h23, 6'h00, 1, 0, 4'd0, 0);
    cyc(0, 6'h23, 6'h00, 1, 0, 4'd1, 0);
    cyc(0, 6'h23, 6'h00, 1, 0, 4'd2, 0);
    cyc(0, 6'h23, 6'h00, 1, 0, 4'd3, 0);
    cyc(0, 6'h23, 6'h00, 1, 0, 4'd4, 0);
    // SW completing immediately
    cyc(0, 6'h2b, 6'h00, 1, 0, 4'd0, 0);
    cyc(0, 6'h2b, 6'h00, 1, 0, 4'd1, 0);
    cyc(0, 6'h2b, 6'h00, 1, 0, 4'd2, 0);
    cyc(0, 6'h2b, 6'h00, 1, 0, 4'd5, 0);
    // Illegal opcode
    cyc(0, 6'h3f, 6'h00, 1, 0, 4'd0, 0);
    cyc(0, 6'h3f, 6'h00, 1, 0, 4'd1, 1);
    // JR
    cyc(0, 6'h00, 6'h08, 1, 0, 4'd0, 0);
`ifdef MULTICYC_JR_EN
    cyc(0, 6'h00, 6'h08, 1, 0, 4'd1, 0);
    cyc(0, 6'h00, 6'h08, 1, 0, 4'd12, 0);
`else
    cyc(0, 6'h00, 6'h08, 1, 0, 4'd1, 1);
`endif
    // SW stalled in MEMWRITE, then reset
    cyc(0, 6'h2b, 6'h00, 1, 0, 4'd0, 0);
    cyc(0, 6'h2b, 6'h00, 1, 0, 4'd1, 0);
    cyc(0, 6'h2b, 6'h00, 0, 0, 4'd2, 0);
    cyc(0, 6'h2b, 6'h00, 0, 0, 4'd5, 0);
    cyc(0, 6'h2b, 6'h00, 0, 0, 4'd5, 0);
    cyc(1, 6'h2b, 6'h00, 0, 0, 4'd5, 0);
    cyc(0, 6'h2b, 6'h00, 0, 0, 4'd0, 0);
    cyc(0, 6'h2b, 6'h00, 1, 0, 4'd0, 0);
    cyc(0, 6'h2b, 6'h00, 1, 0, 4'd1, 0);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicyc_ctrl_unit.md
Name: multicyc_ctrl_unit

Overview:
- Control sequencer for the multi-cycle variant of the MIPS core.
- The instruction and data memories share one port; the PC adder and branch adder are folded into the main ALU.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath mux selects, write enables and ALUOp, and stalls on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of oState.

Ports:
- iClk  input  1  core clock
- iRst  input  1  reset, synchronous, active-high
- iOpCode  input  6  opcode from the instruction register; stable from DECODE until the next IR write
- iFunct  input  6  funct field from the instruction register
- iAluZero  input  1  ALU zero flag
- iMemReady  input  1  memory has completed the current read or write this cycle
- oPCWrite  output  1  unconditional PC write
- oPCWriteCond  output  1  conditional PC write; datapath writes PC when oPCWriteCond & ~(oBranchEq ^ iAluZero)
- oBranchEq  output  1  1 = branch on equal, 0 = branch on not-equal
- oPCSource  output  2  00 = ALU, 01 = ALUOut register, 10 = jump target, 11 = rs
- oIorD  output  1  memory address from 0 = PC, 1 = ALUOut
- oMemRead  output  1  memory read request
- oMemWrite  output  1  memory write request
- oIRWrite  output  1  instruction register load
- oALUSrcA  output  1  0 = PC, 1 = rs data
- oALUSrcB  output  2  00 = rt data, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2
- oALUOp  output  2  00 = add, 01 = sub, 10 = by funct, 11 = by opcode (I-type)
- oRegWrite  output  1  register file write
- oRegDst  output  1  write register 1 = rd, 0 = rt
- oMemtoReg  output  1  write data 1 = memory, 0 = ALUOut
- oRetire  output  1  one-cycle pulse on the final cycle of each completed instruction
- oIllegal  output  1  one-cycle pulse when an unsupported opcode or funct is decoded
- oState  output  STATE_W  current state, for debug

Behaviour:
- Clock and reset: single clock iClk. Reset is synchronous and active-high on iRst.
- Reset: when iRst is high at a rising edge, the state becomes FETCH.
- During any cycle with iRst high, all enables are 0: oPCWrite, oPCWriteCond, oMemRead, oMemWrite, oIRWrite, oRegWrite, oRetire, oIllegal.
- Reset mid-instruction abandons the instruction, including a pending memory wait. No write enable is asserted in the reset cycle.
- Output style: Moore outputs decoded from the state. Exceptions: oIRWrite and oPCWrite in FETCH are gated by iMemReady. Outputs not listed for a state are 0.
- FETCH (0): oMemRead=1, oIorD=0, oALUSrcA=0, oALUSrcB=01, oALUOp=00.
  - If iMemReady: oIRWrite=1, oPCWrite=1, oPCSource=00, next state DECODE.
  - Otherwise hold FETCH. There is no timeout.
- DECODE (1): oALUSrcA=0, oALUSrcB=11, oALUOp=00 (precomputes branch target). Next state by opcode:
  - 0x23, 0x2b -> MEMADDR
  - 0x00 -> EXEC
  - 0x04, 0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x08, 0x09, 0x0c, 0x0a, 0x0b, 0x0f -> IEXEC
  - anything else -> FETCH, with oIllegal=1 and oRetire=0
- MEMADDR (2): oALUSrcA=1, oALUSrcB=10, oALUOp=00. Next state: LW -> MEMREAD, SW -> MEMWRITE.
- MEMREAD (3): oMemRead=1, oIorD=1. Holds until iMemReady, then MEMWB.
- MEMWB (4): oRegWrite=1, oRegDst=0, oMemtoReg=1, oRetire=1. Next state FETCH.
- MEMWRITE (5): oMemWrite=1, oIorD=1. Holds until iMemReady; on that cycle oRetire=1, next state FETCH.
- EXEC (6): oALUSrcA=1, oALUSrcB=00, oALUOp=10. Next state RWB.
- RWB (7): oRegWrite=1, oRegDst=1, oMemtoReg=0, oRetire=1. Next state FETCH.
- BRANCH (8): oALUSrcA=1, oALUSrcB=00, oALUOp=01, oPCWriteCond=1, oBranchEq=(iOpCode==0x04), oPCSource=01, oRetire=1. Next state FETCH.
- JUMP (9): oPCWrite=1, oPCSource=10, oRetire=1. Next state FETCH.
- IEXEC (10): oALUSrcA=1, oALUSrcB=10, oALUOp=11. Next state IWB.
- IWB (11): oRegWrite=1, oRegDst=0, oMemtoReg=0, oRetire=1. Next state FETCH.
- Instruction latency, with zero memory wait: LW 5 cycles; SW, R-type and I-type 4; BEQ/BNE and J 3. Each memory wait cycle adds 1.
- Encodings 12-15 not otherwise used are unreachable; if entered, the next state is FETCH with outputs inactive.

Optional Feature:
- Macro: MULTICYC_JR_EN.
- Defined: in DECODE, opcode 0x00 with funct 0x08 goes to JR (12). JR drives oPCWrite=1, oPCSource=11, oRetire=1, then FETCH. All other funct values go to EXEC.
- Undefined: funct 0x08 under opcode 0x00 is illegal, with the same handling as an unsupported opcode (oIllegal pulse, return to FETCH, no writes).

Test Plan:
- LW, iMemReady low for 2 cycles in both FETCH and MEMREAD -> state sequence 0,0,0,1,2,3,3,3,4,0; oRegWrite=1 and oMemtoReg=1 only in state 4; exactly one oRetire.
- BEQ with iAluZero=1, then BNE with iAluZero=1 -> both show oPCWriteCond=1 in state 8; oBranchEq=1 for BEQ and 0 for BNE; each takes 3 cycles.
- R-type ADD (funct 0x20) then ADDI, iMemReady always 1 -> 4 cycles each; oRegDst=1 in RWB; oRegDst=0 and oALUOp=11 in IEXEC/IWB.
- Opcode 0x3f -> DECODE, then FETCH; oIllegal pulses 1 cycle; no oRegWrite, oMemWrite or oRetire.
- SW held in MEMWRITE with iMemReady=0, then iRst=1 for 1 cycle -> no enables during the reset cycle; state 0 on the next cycle; oMemWrite never seen with iMemReady=1.
- JR (opcode 0x00, funct 0x08) -> with MULTICYC_JR_EN: state 12, oPCSource=11, oPCWrite=1. Without it: oIllegal=1, no PC write.
